// File: rtl/baud_tick_gen_mc.sv
// Multi-channel fractional baud tick generator: each channel emits an oversample tick
// every I+1(+carry) cycles and a bit-rate tick on every OVS-th oversample tick.
module baud_tick_gen_mc #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_wr,
  input  logic [2:0]                            cfg_ch,
  input  logic                                  cfg_en,
  input  logic [CNT_W-1:0]                      cfg_int,
  input  logic [((FRAC_W > 0) ? FRAC_W : 1)-1:0] cfg_frac,
  output logic                                  cfg_ack,
  output logic                                  cfg_err,
  output logic [NCH-1:0]                        baud_tick,
  output logic [NCH-1:0]                        xmit_tick,
  output logic [NCH-1:0]                        pend
);

  localparam int FW = (FRAC_W > 0) ? FRAC_W : 1;
  localparam logic [3:0] SUB_LAST = 4'(OVS - 1);

  logic          ch_ok;
  logic          ack_q, ack_d, err_q, err_d;
  logic [FW-1:0] frac_in;

  assign ch_ok   = ({1'b0, cfg_ch} < 4'(NCH));
  assign frac_in = (FRAC_W > 0) ? cfg_frac : '0;
  assign ack_d   = cfg_wr && ch_ok;
  assign err_d   = cfg_wr && !ch_ok;
  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic             wr_hit;
    logic             en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    acc_q, acc_d;
    logic [3:0]       sub_q, sub_d;
    logic [CNT_W-1:0] ai_q, ai_d, pi_q, pi_d;
    logic [FW-1:0]    af_q, af_d, pf_q, pf_d;
    logic             pv_q, pv_d;
    logic             bt_q, bt_d, xt_q, xt_d;
    logic [FW:0]      acc_sum;
    logic             carry;

    assign wr_hit  = cfg_wr && (cfg_ch == 3'(c));
    assign acc_sum = {1'b0, acc_q} + {1'b0, af_q};
    assign carry   = (FRAC_W > 0) && acc_sum[FW];

    always_comb begin
      en_d  = en_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      sub_d = sub_q;
      ai_d  = ai_q;
      af_d  = af_q;
      pi_d  = pi_q;
      pf_d  = pf_q;
      pv_d  = pv_q;
      bt_d  = 1'b0;
      xt_d  = 1'b0;
      if (en_q) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          bt_d  = 1'b1;
          xt_d  = (sub_q == SUB_LAST);
          sub_d = (sub_q == SUB_LAST) ? 4'd0 : sub_q + 4'd1;
          // A pending divisor takes over at the tick boundary and restarts the fraction.
          if (pv_q) begin
            ai_d  = pi_q;
            af_d  = pf_q;
            cnt_d = pi_q;
            acc_d = '0;
            pv_d  = 1'b0;
          end else begin
            acc_d = acc_sum[FW-1:0];
            cnt_d = ai_q + CNT_W'(carry);
          end
        end
      end
      // Writes land after the tick decision so a same-cycle write becomes the next pending value.
      if (wr_hit) begin
        if (!cfg_en) begin
          en_d  = 1'b0;
          cnt_d = '0;
          acc_d = '0;
          sub_d = 4'd0;
          pv_d  = 1'b0;
          bt_d  = 1'b0;
          xt_d  = 1'b0;
        end else if (!en_q) begin
          en_d  = 1'b1;
          ai_d  = cfg_int;
          af_d  = frac_in;
          cnt_d = '0;
          acc_d = '0;
          sub_d = 4'd0;
          pv_d  = 1'b0;
        end else begin
          pi_d = cfg_int;
          pf_d = frac_in;
          pv_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        en_q  <= 1'b0;
        cnt_q <= '0;
        acc_q <= '0;
        sub_q <= 4'd0;
        ai_q  <= '0;
        af_q  <= '0;
        pi_q  <= '0;
        pf_q  <= '0;
        pv_q  <= 1'b0;
        bt_q  <= 1'b0;
        xt_q  <= 1'b0;
      end else begin
        en_q  <= en_d;
        cnt_q <= cnt_d;
        acc_q <= acc_d;
        sub_q <= sub_d;
        ai_q  <= ai_d;
        af_q  <= af_d;
        pi_q  <= pi_d;
        pf_q  <= pf_d;
        pv_q  <= pv_d;
        bt_q  <= bt_d;
        xt_q  <= xt_d;
      end
    end

    assign baud_tick[c] = bt_q;
    assign xmit_tick[c] = xt_q;
    assign pend[c]      = pv_q;
  end

endmodule

// File: tb/tb_baud_tick_gen_mc.sv
// Scoreboard bench for baud_tick_gen_mc: an event-time channel model predicts every
// output cycle, and a negedge monitor compares the DUT against the queued predictions.
module tb_baud_tick_gen_mc;

  localparam int NCH    = 4;
  localparam int CNT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [2:0]       cfg_ch = 3'd0;
  logic             cfg_en = 1'b0;
  logic [CNT_W-1:0] cfg_int = '0;
  logic [FRAC_W-1:0] cfg_frac = '0;
  logic             cfg_ack, cfg_err;
  logic [NCH-1:0]   baud_tick, xmit_tick, pend;

  baud_tick_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .baud_tick(baud_tick), .xmit_tick(xmit_tick), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef logic [2+3*NCH-1:0] obs_t;  // {ack, err, baud, xmit, pend}

  obs_t sb[$];
  int   t1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc  = 0;
  int   kn    = 0;

  // Reference model: each enabled channel knows the cycle of its next tick.
  bit          m_en [NCH];
  longint      m_next [NCH];
  int          m_I [NCH], m_F [NCH], m_acc [NCH], m_sub [NCH];
  bit          m_pv [NCH];
  int          m_pI [NCH], m_pF [NCH];

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_next[c] = 0; m_I[c] = 0; m_F[c] = 0; m_acc[c] = 0;
      m_sub[c] = 0; m_pv[c] = 0; m_pI[c] = 0; m_pF[c] = 0;
    end
  endtask

  task automatic model_edge(input bit wr, input bit [2:0] ch, input bit en,
                            input int iv, input int fv);
    logic [NCH-1:0] bt, xt, pd;
    bit ack, err;
    int carry;
    bt = '0; xt = '0; pd = '0; ack = 0; err = 0;
    kn++;
    for (int c = 0; c < NCH; c++) begin
      if (m_en[c] && m_next[c] == kn) begin
        bt[c] = 1'b1;
        xt[c] = (m_sub[c] == OVS - 1);
        m_sub[c] = (m_sub[c] + 1) % OVS;
        if (m_pv[c]) begin
          m_I[c] = m_pI[c]; m_F[c] = m_pF[c]; m_acc[c] = 0; m_pv[c] = 0;
          m_next[c] = kn + m_I[c] + 1;
        end else begin
          m_acc[c] = m_acc[c] + m_F[c];
          carry = (m_acc[c] >= (1 << FRAC_W)) ? 1 : 0;
          m_acc[c] = m_acc[c] % (1 << FRAC_W);
          m_next[c] = kn + ((m_I[c] + carry) % (1 << CNT_W)) + 1;
        end
      end
    end
    if (wr) begin
      if (int'(ch) >= NCH) err = 1;
      else begin
        ack = 1;
        if (!en) begin
          m_en[ch] = 0; m_pv[ch] = 0; m_sub[ch] = 0; m_acc[ch] = 0;
          bt[ch] = 1'b0; xt[ch] = 1'b0;
        end else if (!m_en[ch]) begin
          m_en[ch] = 1; m_I[ch] = iv; m_F[ch] = fv; m_acc[ch] = 0; m_sub[ch] = 0;
          m_pv[ch] = 0; m_next[ch] = kn + 1;
        end else begin
          m_pI[ch] = iv; m_pF[ch] = fv; m_pv[ch] = 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) pd[c] = m_pv[c];
    sb.push_back({ack, err, bt, xt, pd});
  endtask

  task automatic step(input bit wr, input bit [2:0] ch, input bit en,
                      input int iv, input int fv);
    cfg_wr = wr; cfg_ch = ch; cfg_en = en;
    cfg_int = CNT_W'(iv); cfg_frac = FRAC_W'(fv);
    @(posedge clk);
    model_edge(wr, ch, en, iv, fv);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 0, 0, 0);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_int("outputs_at_reset", int'({cfg_ack, cfg_err, baud_tick, xmit_tick, pend}), 0);
    model_clear();
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    obs_t exp_v, got_v;
    ncyc++;
    if (!reset && sb.size() > 0) begin
      exp_v = sb.pop_front();
      got_v = {cfg_ack, cfg_err, baud_tick, xmit_tick, pend};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle %0d {ack,err,baud,xmit,pend}: got %b, expected %b", ncyc, got_v, exp_v);
      end
    end
    if (!reset && baud_tick[1]) t1.push_back(ncyc);
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_outputs", int'({cfg_ack, cfg_err, baud_tick, xmit_tick, pend}), 0);
    reset = 1'b0;

    idle(6);
    // ch0 I=3: first tick 2 cycles after the write, then every 4, xmit every 16th
    step(1, 3'd0, 1, 3, 0);
    idle(80);

    // ch1 I=9 F=8: periods 10, 11, ... and 168 cycles over 16 ticks
    t1.delete();
    step(1, 3'd1, 1, 9, 8);
    idle(185);
    check_int("ch1_tick_count_ge17", (t1.size() >= 17) ? 1 : 0, 1);
    if (t1.size() >= 17) begin
      check_int("ch1_period0", t1[1] - t1[0], 10);
      check_int("ch1_period1", t1[2] - t1[1], 11);
      check_int("ch1_16_periods", t1[16] - t1[0], 168);
    end

    // ch2 I=5 then live rewrite to I=1
    step(1, 3'd2, 1, 5, 0);
    idle(9);
    step(1, 3'd2, 1, 1, 0);
    idle(20);

    // out-of-range channel
    step(1, 3'd7, 1, 2, 0);
    idle(4);

    // all channels I=0, then disable ch3
    step(1, 3'd0, 1, 0, 0);
    step(1, 3'd1, 1, 0, 0);
    step(1, 3'd2, 1, 0, 0);
    step(1, 3'd3, 1, 0, 0);
    idle(20);
    step(1, 3'd3, 0, 0, 0);
    idle(6);

    // reset while ch0 has a pending value
    step(1, 3'd0, 1, 20, 0);
    reset_mid();
    idle(40);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) reset_mid();
      else if ($urandom_range(0, 5) == 0)
        step(1, 3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
             int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      else idle(1);
    end

    @(negedge clk);
    #2;
    check_int("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen_mc.md
BAUD_TICK_GEN_MC -- requirements
Module: baud_tick_gen_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent baud channels, 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: integer divisor width.
REQ-003 SHALL have parameter FRAC_W, default 4: fractional divisor width, 0..8; 0 removes fractional logic.
REQ-004 SHALL have parameter OVS, default 16: oversample ratio (baud_tick per xmit_tick), 4..16.
REQ-005 SHALL have port clk, input, 1: single clock; every register is on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-007 SHALL have port cfg_wr, input, 1: one-cycle config write strobe.
REQ-008 SHALL have port cfg_ch, input, 3: target channel index.
REQ-009 SHALL have port cfg_en, input, 1: channel enable value.
REQ-010 SHALL have port cfg_int, input, CNT_W: integer divisor I.
REQ-011 SHALL have port cfg_frac, input, max(FRAC_W,1): fractional divisor F in units of 2^-FRAC_W.
REQ-012 SHALL have port cfg_ack, output, 1: write accepted, one cycle.
REQ-013 SHALL have port cfg_err, output, 1: write rejected, one cycle.
REQ-014 SHALL have port baud_tick, output, NCH: per-channel oversample tick pulse.
REQ-015 SHALL have port xmit_tick, output, NCH: per-channel bit-rate tick pulse.
REQ-016 SHALL have port pend, output, NCH: per-channel config pending, not yet applied.

Function
REQ-017 Each channel SHALL hold these registers: en, cnt[CNT_W], acc[FRAC_W], sub[4], active I/F, and pending I/F/valid.
REQ-018 On an enabled channel, when cnt!=0 the block SHALL set cnt<=cnt-1 and register baud_tick=0.
REQ-019 On an enabled channel, when cnt==0 the block SHALL register baud_tick=1, compute {carry,acc}<=acc+F_active, and load cnt<=I_active+carry.
REQ-020 Tick period SHALL be I+1 cycles, extended to I+2 on carry; the average period SHALL be exactly I+1+F/2^FRAC_W over 2^FRAC_W ticks.
REQ-021 The first tick after enable SHALL have period I+1, i.e. no carry on the first tick.
REQ-022 baud_tick SHALL be registered and high for exactly one clk per tick.
REQ-023 sub SHALL increment on each baud_tick and wrap at OVS-1 to 0.
REQ-024 xmit_tick SHALL be high in the same cycle as the baud_tick for which sub was OVS-1 before incrementing.
REQ-025 xmit_tick SHALL never be high without baud_tick.
REQ-026 cfg_wr with cfg_ch<NCH SHALL assert cfg_ack in the next cycle.
REQ-027 cfg_wr with cfg_ch>=NCH SHALL assert cfg_err in the next cycle and leave all state unchanged.
REQ-028 A write with cfg_en=0 SHALL, in the next cycle, clear en, cnt, acc, sub, pending valid and the channel's tick outputs.
REQ-029 A write with cfg_en=1 to a disabled channel SHALL load active I/F, set cnt=0 and acc=0, and produce the first baud_tick 2 cycles after cfg_wr.
REQ-030 A write with cfg_en=1 to an enabled channel SHALL store pending I/F and set pend.
REQ-031 Pending I/F SHALL become active at the next cnt==0 cycle; at that cycle cnt<=I_new, acc<=0, pend<=0, sub unchanged, and baud_tick is still asserted.
REQ-032 A new write SHALL overwrite any unapplied pending value (last write wins).
REQ-033 If cfg_wr arrives in the same cycle as an apply, the apply SHALL use the old pending value and the new value SHALL become pending.
REQ-034 With I=0, a channel SHALL tick every cycle, or miss a cycle on carry.
REQ-035 cnt and acc SHALL wrap modulo their width; no saturation.
REQ-036 Channels SHALL be fully independent; simultaneous ticks on all channels SHALL be legal.

Reset
REQ-037 Asserting reset SHALL immediately clear all channel registers; baud_tick, xmit_tick, pend, cfg_ack and cfg_err SHALL all be 0.
REQ-038 After reset every channel SHALL be disabled.
REQ-039 Reset asserted mid-period or mid-pending SHALL discard all state.
REQ-040 Release of reset SHALL be synchronous to clk; no ticks SHALL occur until a channel is enabled.

Verification
REQ-041 ch0 I=3 F=0 en=1 -> first baud_tick 2 cycles after cfg_wr, then every 4 cycles; xmit_tick on every 16th baud_tick.
REQ-042 FRAC_W=4, ch1 I=9 F=8 -> periods alternate 10,11; total 168 cycles over 16 ticks.
REQ-043 ch2 running I=5; rewrite I=1 mid-period -> pend=1, old period completes, then period 2, pend=0, sub continuous.
REQ-044 cfg_ch=7 with NCH=4 -> cfg_err=1 for one cycle, cfg_ack=0, all ticks unchanged.
REQ-045 All 4 channels I=0 F=0 -> baud_tick=4'b1111 every cycle; cfg_en=0 on ch3 -> bit 3 low from the following cycle.
REQ-046 Reset asserted while ch0 pend=1 -> outputs 0 at once; after release no tick until a new enable.
